// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU.
// Holds the instruction-field positions, the opcode map, the FSM state
// encoding and small opcode-classification helpers used by the core and ALU.
package cpu_pkg;

    localparam int INSTR_W = 8;

    // Instruction field positions
    localparam int OPC_HI  = 7;
    localparam int OPC_LO  = 4;
    localparam int RD_HI   = 3;
    localparam int RD_LO   = 2;
    localparam int RS_HI   = 1;
    localparam int RS_LO   = 0;
    localparam int IMM4_HI = 3;
    localparam int IMM4_LO = 0;

    // Opcodes
    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_LI   = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } cpu_state_t;

    // Arithmetic, logic, compare and shift instructions update Z/C/S.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_OR,
                          OP_ADDI, OP_XOR, OP_SHL, OP_SHR};
    endfunction

    // Instructions that write the ALU result back into Rd (LD is separate:
    // it always targets R0 with memory data).
    function automatic logic op_writes_rd(input logic [3:0] op);
        return op inside {OP_LI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_ADDI, OP_XOR, OP_SHL, OP_SHR};
    endfunction

    // Instructions whose second ALU operand is the 2-bit immediate.
    function automatic logic op_uses_imm(input logic [3:0] op);
        return op inside {OP_LI, OP_ADDI, OP_SHL, OP_SHR};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle CPU.
// Ports:
//   opcode  in  4       instruction opcode
//   a       in  DATA_W  Rd operand
//   b       in  DATA_W  Rs operand or sign-extended imm2 (shift amount = b[1:0])
//   result  out DATA_W  operation result (LI/MOV pass b through)
//   z, c, s out 1       zero, carry/borrow/shifted-out bit, sign of result
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              s
);

    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic [DATA_W:0] shl_ext;
    logic [DATA_W:0] shr_ext;
    logic [1:0]      shamt;

    always_comb begin
        shamt    = b[1:0];
        sum_ext  = {1'b0, a} + {1'b0, b};
        // With zero-extended operands the top bit of the difference is set
        // exactly when a < b (unsigned), i.e. it is the borrow.
        diff_ext = {1'b0, a} - {1'b0, b};
        // One guard bit above (SHL) or below (SHR) catches the last bit
        // shifted out; a shift of 0 leaves the guard at 0.
        shl_ext  = {1'b0, a} << shamt;
        shr_ext  = {a, 1'b0} >> shamt;

        result = a;
        c      = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                result = sum_ext[DATA_W-1:0];
                c      = sum_ext[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                result = diff_ext[DATA_W-1:0];
                c      = diff_ext[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_ext[DATA_W-1:0];
                c      = shl_ext[DATA_W];
            end
            OP_SHR: begin
                result = shr_ext[DATA_W:1];
                c      = shr_ext[0];
            end
            OP_LI, OP_MOV: result = b;
            default: result = a;
        endcase

        z = (result == '0);
        s = result[DATA_W-1];
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Four-cycle-per-instruction 8-bit-instruction CPU.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start                 run from address 0 (accepted only in IDLE/HALT)
//   last_add [PC_W]       final program address; core halts after retiring it
//   prog_we/addr/data     instruction-memory load port (IDLE/HALT only)
//   busy, halted          FETCH..WB / HALT state indicators
//   pc [PC_W]             program counter
//   z_flag,c_flag,s_flag  registered flags
//   instr_count [16]      retired instructions, saturating
//   dbg_sel [2]/dbg_data  combinational register-file read
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int DMEM_DEPTH = 16,
    parameter  int IMEM_DEPTH = 256,
    localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   last_add,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    output logic              busy,
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    output logic              z_flag,
    output logic              c_flag,
    output logic              s_flag,
    output logic [15:0]       instr_count,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DA_W = $clog2(DMEM_DEPTH);

    cpu_state_t state_reg, state_next;

    logic [PC_W-1:0]    pc_reg;
    logic [15:0]        count_reg;
    logic               z_flag_reg, c_flag_reg, s_flag_reg;

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

    logic [INSTR_W-1:0] fetch_data_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic [DATA_W-1:0]  rd_val_reg, rs_val_reg;
    logic [DATA_W-1:0]  result_reg, ld_data_reg;
    logic               z_res_reg, c_res_reg, s_res_reg;

    logic [DATA_W-1:0]  regs [4];

    logic               idle_like;
    logic [3:0]         opcode;
    logic [1:0]         rd_sel;
    logic [1:0]         fetch_rd, fetch_rs;
    logic [3:0]         ir_imm4;
    logic signed [3:0]  off4;
    logic [DATA_W-1:0]  imm2_sext;
    logic [DA_W-1:0]    dmem_addr;

    logic [DATA_W-1:0]  alu_b, alu_result;
    logic               alu_z, alu_c, alu_s;

    logic               jump_taken, halt_now;
    logic [PC_W-1:0]    pc_plus1, jump_target;
    int                 jump_sum;

    logic               reg_we;
    logic [1:0]         reg_wsel;
    logic [DATA_W-1:0]  reg_wdata;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    assign idle_like = (state_reg == IDLE) || (state_reg == HALT);
    assign opcode    = ir_reg[OPC_HI:OPC_LO];
    assign rd_sel    = ir_reg[RD_HI:RD_LO];
    assign ir_imm4   = ir_reg[IMM4_HI:IMM4_LO];
    assign off4      = ir_reg[IMM4_HI:IMM4_LO];
    assign fetch_rd  = fetch_data_reg[RD_HI:RD_LO];
    assign fetch_rs  = fetch_data_reg[RS_HI:RS_LO];
    assign imm2_sext = {{(DATA_W-2){ir_reg[RS_HI]}}, ir_reg[RS_HI:RS_LO]};
    assign dmem_addr = DA_W'(int'(ir_imm4) % DMEM_DEPTH);

    // ------------------------------------------------------------------
    // Instruction memory: load port when idle, registered read in FETCH
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && idle_like && prog_we) begin
            imem[prog_addr] <= prog_data;
        end
        if (state_reg == FETCH) begin
            fetch_data_reg <= imem[pc_reg];
        end
    end

    // ------------------------------------------------------------------
    // Data memory: registered read in EXEC (LD), write in WB (ST).
    // The write is gated by reset so an aborted ST never lands.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && (state_reg == WB) && (opcode == OP_ST)) begin
            dmem[dmem_addr] <= regs[0];
        end
        if ((state_reg == EXEC) && (opcode == OP_LD)) begin
            ld_data_reg <= dmem[dmem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Datapath pipeline registers (no architectural state, no reset)
    // ------------------------------------------------------------------
    assign alu_b = op_uses_imm(opcode) ? imm2_sext : rs_val_reg;

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (opcode),
        .a      (rd_val_reg),
        .b      (alu_b),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c),
        .s      (alu_s)
    );

    always_ff @(posedge clk) begin
        if (state_reg == DECODE) begin
            ir_reg     <= fetch_data_reg;
            rd_val_reg <= regs[fetch_rd];
            rs_val_reg <= regs[fetch_rs];
        end
        if (state_reg == EXEC) begin
            result_reg <= alu_result;
            z_res_reg  <= alu_z;
            c_res_reg  <= alu_c;
            s_res_reg  <= alu_s;
        end
    end

    // ------------------------------------------------------------------
    // Write-back control
    // ------------------------------------------------------------------
    always_comb begin
        jump_taken = 1'b0;
        if (opcode == OP_JZ) begin
            jump_taken = z_flag_reg;
        end else if (opcode == OP_JC) begin
            jump_taken = c_flag_reg;
        end
        // A taken branch at last_add redirects rather than halts, so a
        // loop closing on the final address keeps running.
        halt_now = (opcode == OP_HLT) || ((pc_reg == last_add) && !jump_taken);
    end

    always_comb begin
        pc_plus1 = (pc_reg == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc_reg + PC_W'(1);
        jump_sum = int'(pc_reg) + int'(off4);
        jump_sum = jump_sum % IMEM_DEPTH;
        if (jump_sum < 0) begin
            jump_sum = jump_sum + IMEM_DEPTH;
        end
        jump_target = PC_W'(jump_sum);
    end

    always_comb begin
        reg_we    = 1'b0;
        reg_wsel  = rd_sel;
        reg_wdata = result_reg;
        if (state_reg == WB) begin
            if (opcode == OP_LD) begin
                reg_we    = 1'b1;
                reg_wsel  = 2'd0;
                reg_wdata = ld_data_reg;
            end else if (op_writes_rd(opcode)) begin
                reg_we = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file R0..R3
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg
            logic [DATA_W-1:0] r_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_reg <= '0;
                end else if (reg_we && (reg_wsel == 2'(gi))) begin
                    r_reg <= reg_wdata;
                end
            end
            assign regs[gi] = r_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM and architectural state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, HALT: if (start) state_next = FETCH;
            FETCH:      state_next = DECODE;
            DECODE:     state_next = EXEC;
            EXEC:       state_next = WB;
            WB:         state_next = halt_now ? HALT : FETCH;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            count_reg  <= '0;
            z_flag_reg <= 1'b0;
            c_flag_reg <= 1'b0;
            s_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        pc_reg    <= '0;
                        count_reg <= '0;
                    end
                end
                WB: begin
                    if (op_sets_flags(opcode)) begin
                        z_flag_reg <= z_res_reg;
                        c_flag_reg <= c_res_reg;
                        s_flag_reg <= s_res_reg;
                    end
                    if (count_reg != 16'hFFFF) begin
                        count_reg <= count_reg + 16'd1;
                    end
                    // On halt pc keeps the address of the retired instruction.
                    if (!halt_now) begin
                        pc_reg <= jump_taken ? jump_target : pc_plus1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = (state_reg == FETCH) || (state_reg == DECODE) ||
                         (state_reg == EXEC)  || (state_reg == WB);
    assign halted      = (state_reg == HALT);
    assign pc          = pc_reg;
    assign z_flag      = z_flag_reg;
    assign c_flag      = c_flag_reg;
    assign s_flag      = s_flag_reg;
    assign instr_count = count_reg;
    assign dbg_data    = regs[dbg_sel];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu (DATA_W=8, IMEM 256, DMEM 16).
// An ISA-level model predicts the final state of each program; the
// prediction is queued at start and compared when the core halts.
module tb_multicycle_cpu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  last_add;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;
    logic        z_flag, c_flag, s_flag;
    logic [15:0] instr_count;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    multicycle_cpu #(
        .DATA_W     (8),
        .DMEM_DEPTH (16),
        .IMEM_DEPTH (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .last_add    (last_add),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .z_flag      (z_flag),
        .c_flag      (c_flag),
        .s_flag      (s_flag),
        .instr_count (instr_count),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              pc;
        int              cnt;
        int              cyc;
        int              z;
        int              c;
        int              s;
        logic [3:0][7:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   prog_q[$];
    int   imem_m [256];
    int   dmem_m [16];
    int   rm [4];
    int   zm, cm, sm;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ISA reference model: runs imem_m from address 0 and queues the outcome.
    task automatic model_run(input int last);
        exp_t e;
        int p, cnt, ir, op, rd, rs, imm2, off, a, b, res, t, n, taken, fl;
        bit stop;
        p = 0; cnt = 0; stop = 1'b0;
        while (!stop && cnt < 1000) begin
            ir = imem_m[p];
            op = ir >> 4;
            rd = (ir >> 2) & 3;
            rs = ir & 3;
            imm2 = (rs >= 2) ? rs - 4 : rs;
            off = ((ir & 15) >= 8) ? (ir & 15) - 16 : (ir & 15);
            a = rm[rd]; b = rm[rs]; n = rs;
            taken = 0; fl = 0; res = 0;
            case (op)
                0:  rm[0] = dmem_m[ir & 15];
                1:  dmem_m[ir & 15] = rm[0];
                2:  rm[rd] = imm2 & 255;
                3:  rm[rd] = b;
                4:  begin t = a + b; res = t & 255; cm = (t > 255); fl = 1; rm[rd] = res; end
                5:  begin res = (a - b) & 255; cm = (a < b); fl = 1; rm[rd] = res; end
                6:  begin res = a & b; cm = 0; fl = 1; rm[rd] = res; end
                7:  begin res = (a - b) & 255; cm = (a < b); fl = 1; end
                8:  begin res = a | b; cm = 0; fl = 1; rm[rd] = res; end
                9:  begin t = a + (imm2 & 255); res = t & 255; cm = (t > 255); fl = 1; rm[rd] = res; end
                10: begin res = a ^ b; cm = 0; fl = 1; rm[rd] = res; end
                11: begin res = (a << n) & 255; cm = (n == 0) ? 0 : ((a >> (8 - n)) & 1); fl = 1; rm[rd] = res; end
                12: begin res = a >> n; cm = (n == 0) ? 0 : ((a >> (n - 1)) & 1); fl = 1; rm[rd] = res; end
                13: taken = zm;
                14: taken = cm;
                default: stop = 1'b1;
            endcase
            if (fl != 0) begin
                zm = (res == 0) ? 1 : 0;
                sm = (res >> 7) & 1;
            end
            cnt++;
            if (stop || (p == last && taken == 0)) begin
                stop = 1'b1;
            end else begin
                p = (taken != 0) ? ((p + off + 256) % 256) : ((p + 1) % 256);
            end
        end
        e.pc = p; e.cnt = cnt; e.cyc = 4 * cnt;
        e.z = zm; e.c = cm; e.s = sm;
        for (int i = 0; i < 4; i++) e.r[i] = 8'(rm[i]);
        sb_q.push_back(e);
    endtask

    task automatic write_imem(input int a, input int d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 8'(a);
        prog_data = 8'(d);
        imem_m[a] = d;
    endtask

    // Loads prog_q (address 0 written in the same cycle as start), runs it,
    // and compares against the queued prediction once the core halts.
    task automatic run_prog(input string name, input int last, input bit poke);
        exp_t e;
        int   cyc;
        bit   done;
        for (int i = 0; i < prog_q.size(); i++) imem_m[i] = prog_q[i];
        model_run(last);
        for (int i = 1; i < prog_q.size(); i++) write_imem(i, prog_q[i]);
        @(negedge clk);
        last_add  = 8'(last);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = 8'(prog_q[0]);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            start   = 1'b0;
            prog_we = 1'b0;
            cyc++;
            if (cyc == 1) check({name, ".busy_run"}, 32'(busy), 32'd1);
            if (poke && cyc == 2) begin
                prog_we   = 1'b1;
                prog_addr = 8'd2;
                prog_data = 8'hF0;
            end
            done = halted;
        end
        e = sb_q.pop_front();
        if (!done) check({name, ".halt_timeout"}, 32'(halted), 32'd1);
        // cyc counts samples after the start edge; halted is first seen one
        // sample after the edge that entered HALT.
        check({name, ".cycles"}, 32'(cyc - 1), 32'(e.cyc));
        check({name, ".pc"}, 32'(pc), 32'(e.pc));
        check({name, ".count"}, 32'(instr_count), 32'(e.cnt));
        check({name, ".z"}, 32'(z_flag), 32'(e.z));
        check({name, ".c"}, 32'(c_flag), 32'(e.c));
        check({name, ".s"}, 32'(s_flag), 32'(e.s));
        check({name, ".busy_halt"}, 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s.R%0d", name, i), 32'(dbg_data), 32'(e.r[i]));
        end
        $display("run %-8s pc=%0d count=%0d R=%02h,%02h,%02h,%02h ZCS=%0d%0d%0d",
                 name, pc, instr_count, e.r[0], e.r[1], e.r[2], e.r[3],
                 z_flag, c_flag, s_flag);
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".halted"}, 32'(halted), 32'd0);
        check({name, ".pc"}, 32'(pc), 32'd0);
        check({name, ".count"}, 32'(instr_count), 32'd0);
        check({name, ".flags"}, 32'({z_flag, c_flag, s_flag}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("%s.R%0d", name, i), 32'(dbg_data), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1; start = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; last_add = 8'd255; dbg_sel = '0;
        for (int i = 0; i < 256; i++) imem_m[i] = 0;
        for (int i = 0; i < 16; i++) dmem_m[i] = 0;
        for (int i = 0; i < 4; i++) rm[i] = 0;
        zm = 0; cm = 0; sm = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Clear all of data memory (R0 = 0 after reset).
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(8'h10 + i);
        prog_q.push_back(8'hF0);
        run_prog("dm_init", 255, 1'b0);

        prog_q = '{8'h25, 8'h2B, 8'h46, 8'hF0};
        run_prog("add_wrap", 255, 1'b0);

        prog_q = '{8'h23, 8'h2E, 8'h2B, 8'h5C, 8'hF0};
        run_prog("sub_borr", 255, 1'b0);

        prog_q = '{8'h25, 8'h21, 8'h14, 8'h20, 8'h04, 8'hF0};
        run_prog("st_ld", 255, 1'b0);

        prog_q = '{8'h27, 8'h95, 8'hE2, 8'h21, 8'h22, 8'hD1, 8'hBB, 8'hC6, 8'hF0};
        run_prog("jc_shift", 255, 1'b0);

        // Taken jump at last_add wraps backwards to 254 and keeps running.
        write_imem(254, 8'hF0);
        prog_q = '{8'h70, 8'hDD};
        run_prog("jz_wrap", 1, 1'b0);

        // No HLT: stops after address 2; a load-port write while busy is ignored.
        prog_q = '{8'h21, 8'h95, 8'hB7};
        run_prog("last_add", 2, 1'b1);

        for (int r = 0; r < 4; r++) begin
            prog_q.delete();
            for (int i = 0; i < 10; i++) begin
                prog_q.push_back(int'(($urandom_range(0, 12) << 4) | $urandom_range(0, 15)));
            end
            prog_q.push_back(8'hF0);
            run_prog($sformatf("rand%0d", r), 255, 1'b0);
        end

        // Reset during EXEC of the ADD at address 2.
        write_imem(1, 8'h25);
        write_imem(2, 8'h41);
        write_imem(3, 8'hF0);
        @(negedge clk);
        last_add = 8'd255; start = 1'b1;
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = 8'h21;
        imem_m[0] = 8'h21;
        cyc = 0;
        while (cyc < 11) begin
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            cyc++;
        end
        check("rst_exec.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_exec");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rm[i] = 0;
        zm = 0; cm = 0; sm = 0;
        $display("run rst_exec busy=%0d pc=%0d count=%0d", busy, pc, instr_count);

        prog_q = '{8'h25, 8'h2B, 8'h46, 8'hF0};
        run_prog("after_rst", 255, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
